// File: rtl/disp_pkg.sv
// Shared types for the display source arbiter: FSM states, the latched display word
// and the "all decimal points off" pattern.
package disp_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } disp_arb_state_e;

  typedef struct packed {
    logic [31:0] val;
    logic [7:0]  dp;
  } disp_word_t;

  localparam logic [7:0] DISP_DP_OFF = 8'hFF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping
// modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [2:0]      grant,
  output logic            any_valid
);

  logic [7:0] req_pad;
  logic [3:0] idx;
  logic       found;

  assign req_pad = 8'(req);

  // ptr is always below NREQ, so ptr+k stays below 2*NREQ and one subtraction wraps it
  always_comb begin
    grant     = 3'd0;
    any_valid = |req;
    found     = 1'b0;
    idx       = 4'd0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      if (!found && req_pad[idx[2:0]]) begin
        grant = idx[2:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_src_arbiter.sv
// Round-robin arbiter sharing the 8-digit display between NREQ debug sources, holding
// each winner for DWELL_CYCLES. Optional macro DISP_ID_TAG_EN tags digit 7 with the source id.
//
// state | meaning
// ARB   | waiting for any req_valid; grant and latch on the same edge
// HOLD  | winner displayed; dwell counter runs down to 0
module disp_src_arbiter
  import disp_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*32-1:0] req_data,
  input  logic [NREQ*8-1:0]  req_dp,
  output logic [NREQ-1:0]    req_ready,
  output logic [31:0]        disp_val,
  output logic [7:0]         dp_out,
  output logic [2:0]         active_id,
  output logic               active_vld
);

  localparam int CW = (DWELL_CYCLES < 1) ? 1 : $clog2(DWELL_CYCLES + 1);

  disp_arb_state_e state, state_nxt;
  logic [2:0]      ptr;
  logic [CW-1:0]   cnt;
  disp_word_t      word_r;
  logic [2:0]      grant;
  logic            any_valid;
  logic            take;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .any_valid (any_valid)
  );

  // reset_n gates the handshake so no requester sees ready while reset is held
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    req_ready = '0;
    case (state)
      ARB: begin
        if (any_valid && reset_n) begin
          take      = 1'b1;
          req_ready = {{(NREQ-1){1'b0}}, 1'b1} << grant;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (cnt == '0) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB;
      ptr        <= 3'd0;
      cnt        <= '0;
      word_r.val <= 32'd0;
      word_r.dp  <= DISP_DP_OFF;
      active_id  <= 3'd0;
      active_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        word_r.val <= req_data[32*grant +: 32];
        word_r.dp  <= req_dp[8*grant +: 8];
        active_id  <= grant;
        active_vld <= 1'b1;
        ptr        <= (32'(grant) + 1 >= NREQ) ? 3'd0 : grant + 3'd1;
        cnt        <= CW'(DWELL_CYCLES - 1);
      end else if (state == HOLD && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

`ifdef DISP_ID_TAG_EN
  // tag only once something was accepted, so reset values stay clean
  assign disp_val = active_vld ? {1'b0, active_id, word_r.val[27:0]} : word_r.val;
  assign dp_out   = active_vld ? {1'b0, word_r.dp[6:0]} : word_r.dp;
`else
  assign disp_val = word_r.val;
  assign dp_out   = word_r.dp;
`endif

endmodule

// File: tb/tb_disp_src_arbiter.sv
// Randomized bench for disp_src_arbiter against a cycle-count based reference model.
module tb_disp_src_arbiter;

  localparam int NREQ  = 4;
  localparam int DWELL = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*32-1:0] req_data = '0;
  logic [NREQ*8-1:0]  req_dp = '0;
  logic [NREQ-1:0]    req_ready;
  logic [31:0]        disp_val;
  logic [7:0]         dp_out;
  logic [2:0]         active_id;
  logic               active_vld;

  disp_src_arbiter #(.NREQ(NREQ), .DWELL_CYCLES(DWELL)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_dp     (req_dp),
    .req_ready  (req_ready),
    .disp_val   (disp_val),
    .dp_out     (dp_out),
    .active_id  (active_id),
    .active_vld (active_vld)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: what the display should show and when the next grant is allowed
  int          m_ptr, m_id, m_vld, m_last, cyc;
  logic [31:0] m_val;
  logic [7:0]  m_dp;
  logic [NREQ-1:0] granted;
  int gcyc[$];
  int gid[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_id = 0; m_vld = 0; m_last = -1000;
    m_val = 32'd0; m_dp = 8'hFF; granted = '0;
  endtask

  function automatic logic [31:0] exp_val();
`ifdef DISP_ID_TAG_EN
    if (m_vld != 0) return {1'b0, 3'(m_id), m_val[27:0]};
`endif
    return m_val;
  endfunction

  function automatic logic [7:0] exp_dp();
`ifdef DISP_ID_TAG_EN
    if (m_vld != 0) return {1'b0, m_dp[6:0]};
`endif
    return m_dp;
  endfunction

  task automatic set_inputs(input int mode);
    for (int i = 0; i < NREQ; i++) begin
      case (mode)
        0: begin
          if (req_valid[i] && granted[i]) req_valid[i] = 1'b0;
          else if (req_valid[i] && ($urandom % 16 == 0)) req_valid[i] = 1'b0;
          else if (!req_valid[i] && ($urandom % 3 == 0)) begin
            req_valid[i] = 1'b1;
            req_data[32*i +: 32] = $urandom;
            req_dp[8*i +: 8] = 8'($urandom);
          end
        end
        1: begin
          if (granted[i] || !req_valid[i]) begin
            req_data[32*i +: 32] = $urandom;
            req_dp[8*i +: 8] = 8'($urandom);
          end
          req_valid[i] = 1'b1;
        end
        2: begin
          req_valid[i] = (i == 2);
          if (i == 2) begin
            req_data[32*i +: 32] = 32'h1234_ABCD;
            req_dp[8*i +: 8] = 8'hA5;
          end
        end
        3: begin
          req_valid[i] = (i == 1) && (cyc - m_last < DWELL + 1);
          if (i == 1) req_data[32*i +: 32] = 32'hDEAD_BEEF;
        end
        default: begin
          req_valid[i] = (i == 3);
          if (i == 3) begin
            req_data[32*i +: 32] = 32'hFFFF_FFFF;
            req_dp[8*i +: 8] = 8'hFF;
          end
        end
      endcase
    end
    granted = '0;
  endtask

  task automatic step(input int mode);
    int g;
    logic [NREQ-1:0] exp_ready;
    set_inputs(mode);
    @(negedge clk);
    g = -1;
    if (cyc - m_last >= DWELL + 1) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
    end
    exp_ready = (g >= 0) ? NREQ'(1) << g : '0;
    chk("ready", req_ready, exp_ready);
    chk("onehot", $countones(req_ready) <= 1, 1);
    chk("disp_val", disp_val, exp_val());
    chk("dp_out", dp_out, exp_dp());
    chk("active_id", active_id, m_id);
    chk("active_vld", active_vld, m_vld);
    if (g >= 0) begin
      m_val  = req_data[32*g +: 32];
      m_dp   = req_dp[8*g +: 8];
      m_id   = g;
      m_vld  = 1;
      m_ptr  = (g + 1) % NREQ;
      m_last = cyc;
      granted[g] = 1'b1;
      gcyc.push_back(cyc);
      gid.push_back(g);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_until_grant(input int mode, input string tag);
    int n;
    n = 0;
    granted = '0;
    while (granted == '0 && n < 3 * DWELL + 10) begin
      step(mode);
      n++;
    end
    chk({tag, "_grant_timeout"}, granted != '0, 1);
  endtask

  initial begin
    model_reset();
    cyc = 0;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = $urandom;
    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_disp", disp_val, 0);
    chk("rst_dp", dp_out, 8'hFF);
    chk("rst_vld", active_vld, 0);
    chk("rst_id", active_id, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    req_valid = '0;

    // single source: regranted every DWELL+1 cycles
    gcyc.delete(); gid.delete();
    repeat (2 * (DWELL + 1) + 2) step(2);
    chk("single_count", gcyc.size(), 3);
    if (gcyc.size() >= 2) begin
      chk("single_gap", gcyc[1] - gcyc[0], DWELL + 1);
      chk("single_id", gid[1], 2);
    end
    chk("single_val", disp_val, 32'h1234_ABCD);

    // withdrawn request during HOLD never granted
    step_until_grant(2, "wd");
    gcyc.delete(); gid.delete();
    repeat (2 * DWELL + 4) step(3);
    chk("wd_no_grant", gcyc.size(), 0);
    chk("wd_disp", disp_val, 32'h1234_ABCD);

    // all valid: rotation with fixed spacing
    gcyc.delete(); gid.delete();
    repeat (5 * (DWELL + 1) + 2) step(1);
    chk("rot_count", gcyc.size() >= 5, 1);
    for (int k = 1; k < gcyc.size(); k++) begin
      chk("rot_gap", gcyc[k] - gcyc[k-1], DWELL + 1);
      chk("rot_order", gid[k], (gid[k-1] + 1) % NREQ);
    end

    // randomized traffic
    req_valid = '0;
    repeat (2000) step(0);

    // reset in the middle of HOLD, then req3 alone from ptr=0
    step_until_grant(2, "mh");
    step(2);
    reset_n = 1'b0;
    req_valid = '1;
    #1;
    chk("mh_ready", req_ready, 0);
    chk("mh_disp", disp_val, 0);
    chk("mh_dp", dp_out, 8'hFF);
    chk("mh_vld", active_vld, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    m_ptr = 0;
    gcyc.delete(); gid.delete();
    step(4);
    chk("mh_first_grant", gid.size() > 0 ? gid[0] : -1, 3);
    step(4);
`ifdef DISP_ID_TAG_EN
    chk("tag_disp", disp_val, 32'h3FFF_FFFF);
    chk("tag_dp", dp_out, 8'h7F);
`else
    chk("tag_disp", disp_val, 32'hFFFF_FFFF);
    chk("tag_dp", dp_out, 8'hFF);
`endif
    chk("tag_id", active_id, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
